mac_sound_pwm: RTL and testbench
================================

Name: mac_sound_pwm

Overview:
- Downstream consumer of the address controller's sound slot: captures the sound sample byte from the RAM data bus whenever `loadSound` strobes.
- Applies sound-enable and 3-bit volume scaling, then drives a 1-bit PWM (or delta-sigma) audio output pin.
- Runs entirely on `clk8`.
- Double-buffers the output level so the level only changes at a modulation-period boundary.

Parameters:
- SAMPLE_HI, 1, 1 = sample is `memoryDataIn[15:8]`; 0 = sample is `memoryDataIn[7:0]`.
- PWM_BITS, 8, PWM counter width; must be >= 8; period = 2^PWM_BITS clk8 cycles.

Ports:
- clk8  input  1  8.125 MHz system clock; all logic on posedge.
- _reset  input  1  synchronous active-low reset.
- loadSound  input  1  one-cycle strobe; `memoryDataIn` holds the sound word during this cycle.
- memoryDataIn  input  16  RAM read data bus.
- sndEnable  input  1  1 = sound on, 0 = muted.
- sndVolume  input  3  volume 0 (quietest) to 7 (full).
- sndSample  output  8  current scaled sample, offset-binary.
- sampleValid  output  1  one-cycle pulse when `sndSample` updates.
- sndOut  output  1  modulated audio bit.

Behaviour:
- Interface: one clock `clk8`; reset is synchronous and active-low on `_reset`, sampled at posedge clk8.
- Reset values (`_reset` = 0 at a posedge):
  - rawReg = 0x80, sndSample = 0x80, pwmLevel = 0x80.
  - pwmCnt = 0, sampleValid = 0.
  - sndOut then reflects the reset state, i.e. high for the first half of the period.
- Stage 1 (capture):
  - At a posedge with loadSound = 1: rawReg <= selected byte of `memoryDataIn`.
  - Otherwise rawReg holds.
- Stage 2 (scale): at the posedge after a capture:
  - s = rawReg ^ 0x80, taken as signed 8-bit (-128..127).
  - p = s * (sndVolume + 1), signed 11-bit.
  - r = p >>> 3, arithmetic shift, fits in signed 8-bit.
  - sndSample <= r ^ 0x80.
  - If sndEnable = 0: sndSample <= 0x80 regardless of data.
  - sampleValid = 1 for exactly that one cycle.
- Latency: loadSound at edge N -> sndSample/sampleValid at edge N+1 after capture (2 edges total).
- Back-to-back loadSound: every strobe produces one sampleValid; no drop, no merge.
- Volume/enable are sampled only at stage 2. Changes between samples take effect on the next loadSound, not retroactively.
- PWM:
  - pwmCnt is free-running, +1 per clk8, wraps from all-ones to 0.
  - At the posedge where pwmCnt = all-ones: pwmLevel <= sndSample (sampled before that edge's update).
  - If sndSample updates on the same wrap edge, the old value is loaded and the new one is picked up next period.
  - sndOut = (pwmCnt < {pwmLevel, PWM_BITS-8 zeros}), driven combinationally from registers.
  - Level 0x00 -> sndOut constantly 0.
  - Level 0xFF -> high for 255/256 of the period (PWM_BITS = 8).
- Reset mid-period: counter and level return to reset values at that edge; any pending stage-2 result is discarded.

Optional Feature:
- Macro: SND_DELTASIGMA_EN.
- Defined:
  - PWM counter is replaced by a first-order delta-sigma modulator.
  - 9-bit accumulator acc, reset 0: acc <= {1'b0, acc[7:0]} + pwmLevel every clk8.
  - sndOut = acc[8] (registered).
  - pwmLevel is updated immediately when sampleValid = 1; no period double-buffer.
  - PWM_BITS is ignored.
- Undefined: PWM behaviour exactly as above.

Test Plan:
- Reset: hold _reset = 0 for 3 cycles, release -> sndSample = 0x80, sampleValid = 0, sndOut high for 128 and low for 128 of the next 256 cycles.
- Full scale: loadSound with memoryDataIn = 0xFF34, vol 7, enable 1 -> sampleValid 2 edges later, sndSample = 0xFF; next period sndOut high 255 cycles. Same stimulus with 0x0034 -> sndSample = 0x00; sndOut never high.
- Volume: data 0xFF00, vol 0 -> sndSample = 0x8F. Data 0x0000, vol 0 -> 0x70. Data 0xC000, vol 3 -> 0xA0.
- Mute: sndEnable = 0, data 0xFFFF -> sndSample = 0x80, sampleValid still pulses.
- Boundary: sampleValid lands exactly on the pwmCnt = 0xFF edge -> current period keeps the old level; new level applies from the following wrap. Also: loadSound on 3 consecutive cycles -> 3 sampleValid pulses, final sndSample from the 3rd word.
- With SND_DELTASIGMA_EN defined: level 0x40 held for 256 cycles -> sndOut high exactly 64 cycles; level 0x00 -> always 0.

Source files
------------

// File: rtl/mac_sound_pwm_if.sv
// Sound-path bus between the RAM/address controller side and mac_sound_pwm.
interface mac_sound_pwm_if;
    logic        loadSound;
    logic [15:0] memoryDataIn;
    logic        sndEnable;
    logic [2:0]  sndVolume;
    logic [7:0]  sndSample;
    logic        sampleValid;
    logic        sndOut;

    // Driver side: supplies the sound word, strobe and controls.
    modport master (
        output loadSound, memoryDataIn, sndEnable, sndVolume,
        input  sndSample, sampleValid, sndOut
    );

    // Sound block side.
    modport slave (
        input  loadSound, memoryDataIn, sndEnable, sndVolume,
        output sndSample, sampleValid, sndOut
    );
endinterface

// File: rtl/mac_sound_pwm.sv
// Sound sample capture, volume scaling and 1-bit audio modulation on clk8.
// Optional macro SND_DELTASIGMA_EN swaps the period PWM for a first-order
// delta-sigma modulator whose level follows each new sample immediately.
module mac_sound_pwm #(
    parameter bit          SAMPLE_HI = 1'b1,
    parameter int unsigned PWM_BITS  = 8
) (
    input  logic             clk8,
    input  logic             _reset,
    mac_sound_pwm_if.slave   bus
);
    localparam logic [7:0] MID = 8'h80;

    logic [7:0]        raw_q, raw_d;
    logic              pend_q, pend_d;
    logic [7:0]        sample_q, sample_d;
    logic              valid_q, valid_d;
    logic [7:0]        level_q, level_d;
    logic [7:0]        sel_byte;
    logic signed [10:0] s_ext, gain, prod;
    logic [7:0]        scaled;
    logic              unused_frac;

    // Byte lane carrying the sound sample.
    assign sel_byte = SAMPLE_HI ? bus.memoryDataIn[15:8] : bus.memoryDataIn[7:0];

    // Offset-binary to signed, multiply by (volume+1), divide by 8 with floor.
    always_comb begin
        s_ext  = {{3{~raw_q[7]}}, ~raw_q[7], raw_q[6:0]};
        gain   = {7'd0, 4'({1'b0, bus.sndVolume}) + 4'd1};
        prod   = s_ext * gain;
        scaled = prod[10:3] ^ MID;
    end
    assign unused_frac = ^prod[2:0];

    // Capture and scale pipeline; every strobe yields exactly one valid pulse.
    always_comb begin
        raw_d    = raw_q;
        pend_d   = bus.loadSound;
        sample_d = sample_q;
        valid_d  = pend_q;
        if (bus.loadSound) begin
            raw_d = sel_byte;
        end
        if (pend_q) begin
            sample_d = bus.sndEnable ? scaled : MID;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk8) begin
        if (!_reset) begin
            raw_q    <= MID;
            pend_q   <= 1'b0;
            sample_q <= MID;
            valid_q  <= 1'b0;
            level_q  <= MID;
        end else begin
            raw_q    <= raw_d;
            pend_q   <= pend_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            level_q  <= level_d;
        end
    end

    assign bus.sndSample   = sample_q;
    assign bus.sampleValid = valid_q;

`ifdef SND_DELTASIGMA_EN
    logic [8:0] acc_q, acc_d;

    // Level tracks each new sample; accumulator carry is the output bit.
    always_comb begin
        level_d = valid_q ? sample_q : level_q;
        acc_d   = {1'b0, acc_q[7:0]} + {1'b0, level_q};
    end

    // Modulator accumulator.
    always_ff @(posedge clk8) begin
        if (!_reset) begin
            acc_q <= 9'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus.sndOut = acc_q[8];
`else
    localparam int unsigned SHIFT = PWM_BITS - 8;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] thresh;

    // Free-running period counter; level is reloaded only on the wrap edge.
    always_comb begin
        cnt_d   = cnt_q + PWM_BITS'(1);
        level_d = (&cnt_q) ? sample_q : level_q;
    end

    // Period counter.
    always_ff @(posedge clk8) begin
        if (!_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign thresh     = PWM_BITS'(level_q) << SHIFT;
    assign bus.sndOut = (cnt_q < thresh);
`endif
endmodule

// File: tb/tb_mac_sound_pwm.sv
// Directed bench for mac_sound_pwm with a cycle-level expectation model.
module tb_mac_sound_pwm;
    logic clk8  = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    always #5 clk8 = ~clk8;

    mac_sound_pwm_if sif();

    mac_sound_pwm #(.SAMPLE_HI(1'b1), .PWM_BITS(8)) dut (
        .clk8   (clk8),
        ._reset (rst_n),
        .bus    (sif)
    );

    // Expected result of scaling: signed sample times (vol+1), floor-divided by 8.
    function automatic logic [7:0] exp_scale(input logic [7:0] b, input logic [2:0] v,
                                              input logic en);
        int s, p, r;
        if (!en) return 8'h80;
        s = int'(b) - 128;
        p = s * (int'(v) + 1);
        r = (p >= 0) ? (p / 8) : -((-p + 7) / 8);
        return 8'(r + 128);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state: pending capture, latest sample, active level, position in period.
    logic [7:0] m_raw, m_sample, m_level;
    bit         m_pend, m_valid;
    int         m_pos, m_acc;

    always @(posedge clk8) begin
        if (!rst_n) begin
            m_raw    <= 8'h80;
            m_sample <= 8'h80;
            m_level  <= 8'h80;
            m_pend   <= 1'b0;
            m_valid  <= 1'b0;
            m_pos    <= 0;
            m_acc    <= 0;
        end else begin
            m_pend  <= sif.loadSound;
            m_valid <= m_pend;
            if (sif.loadSound) m_raw <= sif.memoryDataIn[15:8];
            if (m_pend) m_sample <= exp_scale(m_raw, sif.sndVolume, sif.sndEnable);
            m_pos <= (m_pos + 1) % 256;
`ifdef SND_DELTASIGMA_EN
            if (m_valid) m_level <= m_sample;
            m_acc <= (m_acc % 256) + int'(m_level);
`else
            if (m_pos == 255) m_level <= m_sample;
`endif
        end
    end

    function automatic logic exp_out();
`ifdef SND_DELTASIGMA_EN
        return m_acc >= 256;
`else
        return m_pos < int'(m_level);
`endif
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk8) begin
        if (chk_en && rst_n) begin
            check("cyc_sample", 32'(sif.sndSample), 32'(m_sample));
            check("cyc_valid", 32'(sif.sampleValid), 32'(m_valid));
            check("cyc_out", 32'(sif.sndOut), 32'(exp_out()));
        end
    end

    // Strobe one word, then check the pulse and scaled value two edges later.
    task automatic load_check(input string name, input logic [15:0] d, input logic [2:0] v,
                              input logic en, input logic [7:0] exp);
        sif.memoryDataIn = d;
        sif.sndVolume    = v;
        sif.sndEnable    = en;
        sif.loadSound    = 1'b1;
        @(negedge clk8);
        sif.loadSound    = 1'b0;
        @(negedge clk8);
        check({name, "_valid"}, 32'(sif.sampleValid), 32'd1);
        check({name, "_sample"}, 32'(sif.sndSample), 32'(exp));
        @(negedge clk8);
        check({name, "_valid_drop"}, 32'(sif.sampleValid), 32'd0);
    endtask

    // Count high cycles across one full period starting at its first cycle.
    task automatic count_period(output int hi);
        int w;
        w  = 0;
        hi = 0;
        while (m_pos != 0 && w < 600) begin
            @(negedge clk8);
            w++;
        end
        if (w >= 600) check("period_wait_bound", 32'd1, 32'd0);
        hi = int'(sif.sndOut);
        repeat (255) begin
            @(negedge clk8);
            hi += int'(sif.sndOut);
        end
    endtask

    // Count high cycles over 256 consecutive cycles from now.
    task automatic count_window(output int hi);
        hi = 0;
        repeat (256) begin
            @(negedge clk8);
            hi += int'(sif.sndOut);
        end
    endtask

    initial begin
        int hi, nv, w;
        sif.loadSound    = 1'b0;
        sif.memoryDataIn = 16'h0000;
        sif.sndEnable    = 1'b1;
        sif.sndVolume    = 3'd7;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk8);
        check("rst_sample", 32'(sif.sndSample), 32'h80);
        check("rst_valid", 32'(sif.sampleValid), 32'd0);
`ifdef SND_DELTASIGMA_EN
        check("rst_out", 32'(sif.sndOut), 32'd0);
`else
        check("rst_out", 32'(sif.sndOut), 32'd1);
`endif
        rst_n  = 1'b1;
        chk_en = 1'b1;
`ifndef SND_DELTASIGMA_EN
        hi = int'(sif.sndOut);
        repeat (255) begin
            @(negedge clk8);
            hi += int'(sif.sndOut);
        end
        check("rst_period_high", 32'(hi), 32'd128);
`endif

        load_check("full_hi", 16'hFF34, 3'd7, 1'b1, 8'hFF);
`ifndef SND_DELTASIGMA_EN
        count_period(hi);
        check("full_hi_period", 32'(hi), 32'd255);
`endif
        load_check("full_lo", 16'h0034, 3'd7, 1'b1, 8'h00);
`ifndef SND_DELTASIGMA_EN
        count_period(hi);
        check("full_lo_period", 32'(hi), 32'd0);
`endif
        load_check("vol0_max", 16'hFF00, 3'd0, 1'b1, 8'h8F);
        load_check("vol0_min", 16'h0000, 3'd0, 1'b1, 8'h70);
        load_check("vol3_c0", 16'hC000, 3'd3, 1'b1, 8'hA0);
        load_check("mute", 16'hFFFF, 3'd7, 1'b0, 8'h80);

`ifndef SND_DELTASIGMA_EN
        // New sample lands on the wrap edge: old level for one more period.
        w = 0;
        while (m_pos != 254 && w < 600) begin
            @(negedge clk8);
            w++;
        end
        if (w >= 600) check("boundary_wait_bound", 32'd1, 32'd0);
        sif.memoryDataIn = 16'hFF00;
        sif.sndVolume    = 3'd7;
        sif.sndEnable    = 1'b1;
        sif.loadSound    = 1'b1;
        @(negedge clk8);
        sif.loadSound    = 1'b0;
        @(negedge clk8);
        check("boundary_valid", 32'(sif.sampleValid), 32'd1);
        check("boundary_sample", 32'(sif.sndSample), 32'hFF);
        count_period(hi);
        check("boundary_old_level", 32'(hi), 32'd128);
        count_period(hi);
        check("boundary_new_level", 32'(hi), 32'd255);
`endif

        // Three consecutive strobes produce three pulses.
        nv = 0;
        sif.sndVolume    = 3'd7;
        sif.sndEnable    = 1'b1;
        sif.loadSound    = 1'b1;
        sif.memoryDataIn = 16'h1000;
        @(negedge clk8);
        nv += int'(sif.sampleValid);
        sif.memoryDataIn = 16'h2000;
        @(negedge clk8);
        nv += int'(sif.sampleValid);
        sif.memoryDataIn = 16'hC000;
        @(negedge clk8);
        nv += int'(sif.sampleValid);
        sif.loadSound    = 1'b0;
        repeat (4) begin
            @(negedge clk8);
            nv += int'(sif.sampleValid);
        end
        check("b2b_pulses", 32'(nv), 32'd3);
        check("b2b_final", 32'(sif.sndSample), 32'hC0);

`ifdef SND_DELTASIGMA_EN
        load_check("ds_level40", 16'h4000, 3'd7, 1'b1, 8'h40);
        count_window(hi);
        check("ds_high_64", 32'(hi), 32'd64);
        load_check("ds_level00", 16'h0000, 3'd7, 1'b1, 8'h00);
        count_window(hi);
        check("ds_high_0", 32'(hi), 32'd0);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
